// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Brief    : Programmable serial pattern detector with don't-care mask,
//            overlap mode and a saturating, clearable match counter.
// Revision : 1.0
// ============================================================================
module seq_detect_prog #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [MAX_LEN-1:0] cfg_mask_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               valid_i,
  input  logic               x_i,
  input  logic               clear_i,
  output logic               detect_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               cnt_sat_o
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pattern;
  logic [MAX_LEN-1:0] r_mask;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_detect;
  logic [CNT_W-1:0]   r_cnt;

  logic [LEN_W-1:0]   w_cfg_len;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_len_mask;
  logic               w_accept;
  logic               w_match;
  logic               w_cnt_sat;

  // Bits at or above the programmed length never take part in the compare.
  generate
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_len_mask
      assign w_len_mask[i] = (r_len > LEN_W'(i));
    end
  endgenerate

  always_comb begin
    w_cfg_len   = (cfg_len_i > c_max_len) ? c_max_len : cfg_len_i;
    w_hist_next = {r_hist[MAX_LEN-2:0], x_i};
    w_fill_inc  = (r_fill == c_max_len) ? r_fill : r_fill + LEN_W'(1);
    w_accept    = valid_i && !cfg_we_i;
    w_match     = w_accept && (r_len != '0) && (w_fill_inc >= r_len) &&
                  (((w_hist_next ^ r_pattern) & r_mask & w_len_mask) == '0);
    w_cnt_sat   = &r_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern <= '0;
      r_mask    <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_detect  <= 1'b0;
    end else if (cfg_we_i) begin
      // Reconfiguration restarts detection; a bit offered this cycle is dropped.
      r_pattern <= cfg_pattern_i;
      r_mask    <= cfg_mask_i;
      r_len     <= w_cfg_len;
      r_overlap <= cfg_overlap_i;
      r_hist    <= '0;
      r_fill    <= '0;
      r_detect  <= 1'b0;
    end else if (valid_i) begin
      r_hist    <= w_hist_next;
      r_fill    <= (w_match && !r_overlap) ? '0 : w_fill_inc;
      r_detect  <= w_match;
    end else begin
      r_detect  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (w_match && !w_cnt_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign detect_o    = r_detect;
  assign match_cnt_o = r_cnt;
  assign cnt_sat_o   = w_cnt_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_prog
// Brief    : Directed self-checking bench for seq_detect_prog (CNT_W = 2).
// Revision : 1.0
// ============================================================================
module tb_seq_detect_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_we_i;
  logic [MAX_LEN-1:0] cfg_pattern_i;
  logic [MAX_LEN-1:0] cfg_mask_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic               cfg_overlap_i;
  logic               valid_i;
  logic               x_i;
  logic               clear_i;
  logic               detect_o;
  logic [CNT_W-1:0]   match_cnt_o;
  logic               cnt_sat_o;

  int vectors = 0;
  int errs    = 0;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_we_i(cfg_we_i), .cfg_pattern_i(cfg_pattern_i),
    .cfg_mask_i(cfg_mask_i), .cfg_len_i(cfg_len_i), .cfg_overlap_i(cfg_overlap_i),
    .valid_i(valid_i), .x_i(x_i), .clear_i(clear_i), .detect_o(detect_o),
    .match_cnt_o(match_cnt_o), .cnt_sat_o(cnt_sat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one accepted bit; outputs are checked 1 time unit after the edge.
  task automatic bit_in(input logic b);
    valid_i = 1'b1;
    x_i     = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [MAX_LEN-1:0] msk,
                     input logic [LEN_W-1:0] len, input logic ov);
    cfg_pattern_i = pat;
    cfg_mask_i    = msk;
    cfg_len_i     = len;
    cfg_overlap_i = ov;
    cfg_we_i      = 1'b1;
    valid_i       = 1'b0;
    @(posedge clk); #1;
    cfg_we_i      = 1'b0;
  endtask

  task automatic clr();
    clear_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    clear_i = 1'b0;
  endtask

  logic [11:0] p12;
  logic [15:0] p16;
  logic [4:0]  s5;

  initial begin
    reset = 1'b1; cfg_we_i = 1'b0; cfg_pattern_i = '0; cfg_mask_i = '0;
    cfg_len_i = '0; cfg_overlap_i = 1'b0; valid_i = 1'b0; x_i = 1'b0; clear_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_detect", detect_o, 0);
    chk("rst_cnt", match_cnt_o, 0);
    chk("rst_sat", cnt_sat_o, 0);
    #3 reset = 1'b0;

    // 1. Baseline 12-bit pattern, fed oldest bit first
    p12 = 12'b1110_1101_1011;
    cfg(16'(p12), 16'hFFFF, 5'd12, 1'b1);
    for (int i = 11; i >= 0; i--) begin
      bit_in(p12[i]);
      chk($sformatf("t1_det_bit%0d", 12 - i), detect_o, (i == 0));
    end
    chk("t1_cnt", match_cnt_o, 1);
    idle(1);
    chk("t1_pulse_end", detect_o, 0);

    // 2. Overlap vs non-overlap on 1,0,1,0,1
    s5 = 5'b10101;
    clr();
    chk("t2_clear", match_cnt_o, 0);
    cfg(16'b101, 16'hFFFF, 5'd3, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      bit_in(s5[i]);
      chk($sformatf("t2_ov_bit%0d", 5 - i), detect_o, (i == 2 || i == 0));
    end
    chk("t2_ov_cnt", match_cnt_o, 2);
    clr();
    cfg(16'b101, 16'hFFFF, 5'd3, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      bit_in(s5[i]);
      chk($sformatf("t2_nov_bit%0d", 5 - i), detect_o, (i == 2));
    end
    chk("t2_nov_cnt", match_cnt_o, 1);

    // 3. Masked compare with a valid gap
    clr();
    cfg(16'b1001, 16'b1011, 5'd4, 1'b1);
    bit_in(1'b1); chk("t3_b1", detect_o, 0);
    bit_in(1'b1); chk("t3_b2", detect_o, 0);
    for (int g = 0; g < 3; g++) begin
      idle(1);
      chk($sformatf("t3_gap%0d", g), detect_o, 0);
    end
    bit_in(1'b0); chk("t3_b3", detect_o, 0);
    bit_in(1'b1); chk("t3_b4", detect_o, 1);
    chk("t3_cnt", match_cnt_o, 1);

    // 4a. Reconfigure after 2 of 3 bits; the coincident bit is dropped
    clr();
    cfg(16'b101, 16'hFFFF, 5'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b0);
    valid_i = 1'b1; x_i = 1'b1;
    cfg(16'b101, 16'hFFFF, 5'd3, 1'b1);
    chk("t4_cfg_drop", detect_o, 0);
    chk("t4_cfg_cnt", match_cnt_o, 0);
    bit_in(1'b1); chk("t4_f1", detect_o, 0);
    bit_in(1'b0); chk("t4_f2", detect_o, 0);
    bit_in(1'b1); chk("t4_f3", detect_o, 1);
    chk("t4_cnt_kept", match_cnt_o, 1);
    // All-zero pattern: cleared history already matches, only fill can hold it off
    clr();
    cfg(16'b000, 16'hFFFF, 5'd3, 1'b1);
    bit_in(1'b0); chk("t4_z1", detect_o, 0);
    bit_in(1'b0); chk("t4_z2", detect_o, 0);
    bit_in(1'b0); chk("t4_z3", detect_o, 1);

    // 4b. len 0 never matches, even with an empty mask
    clr();
    cfg(16'h0, 16'h0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bit_in(1'b0);
      chk($sformatf("t4_len0_%0d", i), detect_o, 0);
    end
    chk("t4_len0_cnt", match_cnt_o, 0);

    // 4c. len MAX_LEN+5 clamps to MAX_LEN
    p16 = 16'hA5C3;
    cfg(p16, 16'hFFFF, 5'(MAX_LEN + 5), 1'b1);
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      bit_in(p16[i]);
      if (i <= 1) chk($sformatf("t4_clamp_bit%0d", MAX_LEN - i), detect_o, (i == 0));
    end
    chk("t4_clamp_cnt", match_cnt_o, 1);

    // 5. Saturation and clear with a single-bit pattern
    clr();
    cfg(16'b1, 16'hFFFF, 5'd1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      bit_in(1'b1);
      chk($sformatf("t5_det%0d", i), detect_o, 1);
      chk($sformatf("t5_cnt%0d", i), match_cnt_o, (i > 3) ? 3 : i);
      chk($sformatf("t5_sat%0d", i), cnt_sat_o, (i >= 3));
    end
    clear_i = 1'b1;
    bit_in(1'b1);
    clear_i = 1'b0;
    chk("t5_clr_det", detect_o, 1);
    chk("t5_clr_cnt", match_cnt_o, 0);
    chk("t5_clr_sat", cnt_sat_o, 0);
    bit_in(1'b1);
    chk("t5_after_cnt", match_cnt_o, 1);

    // 6. Asynchronous reset mid-operation
    clr();
    cfg(16'b101, 16'hFFFF, 5'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("t6_pre_det", detect_o, 1);
    chk("t6_pre_cnt", match_cnt_o, 1);
    valid_i = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_det", detect_o, 0);
    chk("t6_rst_cnt", match_cnt_o, 0);
    chk("t6_rst_sat", cnt_sat_o, 0);
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("t6_cfg_cleared", detect_o, 0);
    cfg(16'b101, 16'hFFFF, 5'd3, 1'b1);
    bit_in(1'b0); chk("t6_rem1", detect_o, 0);
    bit_in(1'b1); chk("t6_rem2", detect_o, 0);
    bit_in(1'b0); chk("t6_new1", detect_o, 0);
    bit_in(1'b1); chk("t6_new2", detect_o, 1);
    chk("t6_cnt", match_cnt_o, 1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-pattern detector for the single-bit input stream paths. It accepts a run-time pattern of up to MAX_LEN bits with a per-bit don't-care mask, and runs in either overlapping or non-overlapping match mode. Input is qualified by a valid strobe. Every match produces a one-cycle registered pulse and increments a saturating match counter that software can clear.

## Interface
- MAX_LEN, default 16: maximum pattern length in bits; legal range 2..32.
- CNT_W, default 8: match-counter width; legal range 1..32.
- LEN_W, derived as $clog2(MAX_LEN+1): width of cfg_len_i.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, asynchronous, active-high.
- cfg_we_i, input, 1: loads all cfg_* fields and restarts detection.
- cfg_pattern_i, input, MAX_LEN: pattern. Bit 0 is the most recent bit and bit len-1 is the oldest.
- cfg_mask_i, input, MAX_LEN: 1 means compare the bit, 0 means don't care.
- cfg_len_i, input, LEN_W: pattern length. 0 disables detection. Values above MAX_LEN are clamped to MAX_LEN.
- cfg_overlap_i, input, 1: 1 selects overlapping mode, 0 selects non-overlapping mode.
- valid_i, input, 1: x_i is sampled when this is high.
- x_i, input, 1: serial data bit.
- clear_i, input, 1: synchronous clear of the match counter.
- detect_o, output, 1: one-cycle match pulse.
- match_cnt_o, output, CNT_W: saturating match count.
- cnt_sat_o, output, 1: high while match_cnt_o is all ones.

## Operation
**Configuration registers**
- The block holds pattern, mask, len and overlap internally. cfg_we_i latches them.
- Reset values: all configuration registers 0, so detection is disabled.

**History and fill counter**
- The history is a MAX_LEN-bit shift register. On an accepted bit it updates as hist <= {hist[MAX_LEN-2:0], x_i}.
- A fill counter runs from 0 to MAX_LEN and saturates at MAX_LEN. It counts bits accepted since the last restart.

**Match rule**
- A match occurs for an accepted bit when all of the following hold, evaluated on the updated history and fill:
  - len != 0;
  - fill_next >= len;
  - ((hist_next ^ pattern) & mask) is zero over bits [len-1:0].
- Bits at or above len are ignored.

**Match modes**
- Overlapping mode: fill keeps counting, so bits may be shared between consecutive matches.
- Non-overlapping mode: on a match, fill_next is forced to 0. History is kept, but the next match needs len fresh bits.

**Restart**
- A restart is caused by reset or cfg_we_i.
- Restart clears the history and the fill counter, and drives detect_o to 0 on the next edge.
- cfg_we_i has priority over valid_i in the same cycle: that bit is dropped.

**Match counter**
- The counter increments on each match and saturates at 2^CNT_W-1.
- clear_i sets it to 0. If clear_i and a match fall in the same cycle, clear wins and the result is 0.
- cfg_we_i does not touch the counter.
- cnt_sat_o is combinational: match_cnt_o == all ones.

**Idle input**
- When valid_i = 0, history, fill and counter hold, and detect_o goes to 0 on the next edge.

**Reset values of outputs:** detect_o = 0, match_cnt_o = 0, cnt_sat_o = 0.

## Timing
- Bits are accepted at a rising clk edge with valid_i = 1 and cfg_we_i = 0.
- detect_o is registered. It is high for exactly the one cycle following the edge that accepted the completing bit: latency 1 cycle, pulse width 1 cycle.
- Back-to-back matches on consecutive accepted bits produce consecutive high cycles. This is possible in overlapping mode, for example with an all-ones pattern of len 1 after clamping rules.
- match_cnt_o updates on the same edge that sets detect_o.
- New configuration applies to bits accepted from the edge after cfg_we_i onward.
- Asserting reset mid-stream immediately zeros all state and outputs. The first match after release needs len accepted bits.
- The block has no combinational path from any input to detect_o or match_cnt_o.

## Test plan
1. **Baseline 12-bit pattern.** Configure pattern 12'b1110_1101_1011, mask all ones, len 12. Feed those 12 bits oldest first with continuous valid. Required: detect_o high for one cycle, the cycle after the 12th bit; match_cnt_o = 1.
2. **Overlap vs non-overlap.** Configure pattern 3'b101, len 3. Feed stream 1,0,1,0,1.
   - Overlapping: 2 pulses, after bits 3 and 5; count 2.
   - Non-overlapping: 1 pulse, after bit 3; count 1.
3. **Mask and valid gaps.** Configure pattern 4'b1001, mask 4'b1011, len 4. Feed 1,1,0,1 with valid_i low for 3 cycles between bits 2 and 3. Required: 1 pulse, after bit 4; no pulse during the gap.
4. **Mid-stream reconfiguration and len corners.**
   - After 2 of 3 pattern bits, assert cfg_we_i with the same configuration and valid_i = 1. That bit is dropped, and no pulse occurs until 3 fresh matching bits arrive.
   - len 0: no pulses ever.
   - len MAX_LEN+5: behaves as MAX_LEN.
5. **Counter saturation and clear (CNT_W = 2).**
   - 5 matches give count 3 with cnt_sat_o = 1.
   - clear_i coincident with a match gives count 0.
   - The next match gives count 1.
6. **Reset mid-operation.** Assert reset asynchronously between clock edges partway through a pattern. Required: outputs go to 0 immediately, and no pulse occurs for the remainder of the interrupted pattern after release.
